// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter that funnels per-thread LSU read/write
// requests onto a single data-memory port, one transaction in flight at a time.
// Optional feature: define DATA_ARB_TIMEOUT_EN to enable the memory-wait
// watchdog and the sticky timeout_error flag.
module data_mem_arbiter #(
   parameter int unsigned ADDR_BITS      = 8,
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned NUM_CONSUMERS  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
   input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
   output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
   output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
   input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
   input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
   input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
   output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
   output logic                     mem_read_valid,
   output logic [ADDR_BITS-1:0]     mem_read_address,
   input  logic                     mem_read_ready,
   input  logic [DATA_BITS-1:0]     mem_read_data,
   output logic                     mem_write_valid,
   output logic [ADDR_BITS-1:0]     mem_write_address,
   output logic [DATA_BITS-1:0]     mem_write_data,
   input  logic                     mem_write_ready,
   output logic                     timeout_error
);

   localparam int unsigned IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_WAIT,
      S_WRITE_WAIT,
      S_READ_RELAY,
      S_WRITE_RELAY
   } state_e;

   state_e state_q, state_d;

   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]         cur_q, cur_d;
   logic                     mem_read_valid_q, mem_read_valid_d;
   logic [ADDR_BITS-1:0]     mem_read_address_q, mem_read_address_d;
   logic                     mem_write_valid_q, mem_write_valid_d;
   logic [ADDR_BITS-1:0]     mem_write_address_q, mem_write_address_d;
   logic [DATA_BITS-1:0]     mem_write_data_q, mem_write_data_d;
   logic [NUM_CONSUMERS-1:0] read_ready_q, read_ready_d;
   logic [NUM_CONSUMERS-1:0] write_ready_q, write_ready_d;
   logic [DATA_BITS-1:0]     read_data_q [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]     read_data_d [NUM_CONSUMERS];

   logic                     gnt_found_c;
   logic                     gnt_is_read_c;
   logic [IDX_W-1:0]         gnt_idx_c;
   logic [IDX_W-1:0]         scan_idx_c;
   logic                     tmo_c;

   // Round-robin scan starting at rr_ptr; a read beats a write on the same port
   always_comb begin
      gnt_found_c   = 1'b0;
      gnt_is_read_c = 1'b0;
      gnt_idx_c     = '0;
      scan_idx_c    = '0;
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
         scan_idx_c = IDX_W'((32'(rr_ptr_q) + i) % NUM_CONSUMERS);
         if (!gnt_found_c && (consumer_read_valid[scan_idx_c] || consumer_write_valid[scan_idx_c])) begin
            gnt_found_c   = 1'b1;
            gnt_idx_c     = scan_idx_c;
            gnt_is_read_c = consumer_read_valid[scan_idx_c];
         end
      end
   end

`ifdef DATA_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] wait_cnt_q;
   logic             timeout_error_q;
   logic             tmo_fire_c;

   assign tmo_c      = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign tmo_fire_c = tmo_c && (((state_q == S_READ_WAIT)  && !mem_read_ready) ||
                                 ((state_q == S_WRITE_WAIT) && !mem_write_ready));

   // Wait-cycle counter, cleared whenever the FSM is outside the WAIT states
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
      end else if ((state_q == S_READ_WAIT) || (state_q == S_WRITE_WAIT)) begin
         wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end else begin
         wait_cnt_q <= '0;
      end
   end

   // Sticky watchdog flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_error_q <= 1'b0;
      end else if (tmo_fire_c) begin
         timeout_error_q <= 1'b1;
      end
   end

   assign timeout_error = timeout_error_q;
`else
   logic unused_timeout_cfg;

   assign tmo_c              = 1'b0;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES) ^ ^32'(CNT_W);
   assign timeout_error      = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_found_c) begin
               state_d = gnt_is_read_c ? S_READ_WAIT : S_WRITE_WAIT;
            end
         end
         S_READ_WAIT: begin
            if (mem_read_ready || tmo_c) state_d = S_READ_RELAY;
         end
         S_WRITE_WAIT: begin
            if (mem_write_ready || tmo_c) state_d = S_WRITE_RELAY;
         end
         S_READ_RELAY: begin
            if (!consumer_read_valid[cur_q]) state_d = S_IDLE;
         end
         S_WRITE_RELAY: begin
            if (!consumer_write_valid[cur_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and grant bookkeeping
   always_comb begin
      rr_ptr_d            = rr_ptr_q;
      cur_d               = cur_q;
      mem_read_valid_d    = mem_read_valid_q;
      mem_read_address_d  = mem_read_address_q;
      mem_write_valid_d   = mem_write_valid_q;
      mem_write_address_d = mem_write_address_q;
      mem_write_data_d    = mem_write_data_q;
      read_ready_d        = read_ready_q;
      write_ready_d       = write_ready_q;
      read_data_d         = read_data_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_found_c) begin
               cur_d    = gnt_idx_c;
               rr_ptr_d = IDX_W'((32'(gnt_idx_c) + 32'd1) % NUM_CONSUMERS);
               if (gnt_is_read_c) begin
                  mem_read_valid_d   = 1'b1;
                  mem_read_address_d = consumer_read_address[gnt_idx_c];
               end else begin
                  mem_write_valid_d   = 1'b1;
                  mem_write_address_d = consumer_write_address[gnt_idx_c];
                  mem_write_data_d    = consumer_write_data[gnt_idx_c];
               end
            end
         end
         S_READ_WAIT: begin
            if (mem_read_ready) begin
               mem_read_valid_d    = 1'b0;
               read_data_d[cur_q]  = mem_read_data;
               read_ready_d[cur_q] = 1'b1;
            end else if (tmo_c) begin
               mem_read_valid_d    = 1'b0;
               read_data_d[cur_q]  = '0;
               read_ready_d[cur_q] = 1'b1;
            end
         end
         S_WRITE_WAIT: begin
            if (mem_write_ready || tmo_c) begin
               mem_write_valid_d    = 1'b0;
               write_ready_d[cur_q] = 1'b1;
            end
         end
         S_READ_RELAY: begin
            if (!consumer_read_valid[cur_q]) read_ready_d[cur_q] = 1'b0;
         end
         S_WRITE_RELAY: begin
            if (!consumer_write_valid[cur_q]) write_ready_d[cur_q] = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q            <= '0;
         cur_q               <= '0;
         mem_read_valid_q    <= 1'b0;
         mem_read_address_q  <= '0;
         mem_write_valid_q   <= 1'b0;
         mem_write_address_q <= '0;
         mem_write_data_q    <= '0;
         read_ready_q        <= '0;
         write_ready_q       <= '0;
         for (int unsigned i = 0; i < NUM_CONSUMERS; i++) read_data_q[i] <= '0;
      end else begin
         rr_ptr_q            <= rr_ptr_d;
         cur_q               <= cur_d;
         mem_read_valid_q    <= mem_read_valid_d;
         mem_read_address_q  <= mem_read_address_d;
         mem_write_valid_q   <= mem_write_valid_d;
         mem_write_address_q <= mem_write_address_d;
         mem_write_data_q    <= mem_write_data_d;
         read_ready_q        <= read_ready_d;
         write_ready_q       <= write_ready_d;
         for (int unsigned i = 0; i < NUM_CONSUMERS; i++) read_data_q[i] <= read_data_d[i];
      end
   end

   assign mem_read_valid       = mem_read_valid_q;
   assign mem_read_address     = mem_read_address_q;
   assign mem_write_valid      = mem_write_valid_q;
   assign mem_write_address    = mem_write_address_q;
   assign mem_write_data       = mem_write_data_q;
   assign consumer_read_ready  = read_ready_q;
   assign consumer_write_ready = write_ready_q;
   assign consumer_read_data   = read_data_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed stimulus pushes expected
// memory requests and consumer completions; a negedge monitor pops and checks.
module tb_data_mem_arbiter;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [N-1:0]  rd_valid, rd_ready, wr_valid, wr_ready;
   logic [7:0]    rd_addr [N];
   logic [7:0]    rd_data [N];
   logic [7:0]    wr_addr [N];
   logic [7:0]    wr_data [N];
   logic          mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
   logic [7:0]    mem_read_address, mem_read_data, mem_write_address, mem_write_data;
   logic          timeout_error;

   data_mem_arbiter #(
      .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .reset(reset),
      .consumer_read_valid(rd_valid), .consumer_read_address(rd_addr),
      .consumer_read_ready(rd_ready), .consumer_read_data(rd_data),
      .consumer_write_valid(wr_valid), .consumer_write_address(wr_addr),
      .consumer_write_data(wr_data), .consumer_write_ready(wr_ready),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
      .timeout_error(timeout_error)
   );

   typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] data; } mem_exp_t;
   typedef struct packed { logic wr; logic [1:0] idx; logic [7:0] data; } rsp_exp_t;

   mem_exp_t exp_mem [$];
   rsp_exp_t exp_rsp [$];

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem_arr [256];
   bit  mem_en   = 1'b1;
   bit  stale_rd = 1'b0;
   int  mem_lat  = 1;
   int  mem_cnt  = 0;
   int  hold_r [N];
   int  hold_w [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_mem(input logic wr, input logic [7:0] a, input logic [7:0] d);
      mem_exp_t e;
      e.wr = wr; e.addr = a; e.data = d;
      exp_mem.push_back(e);
   endtask

   task automatic push_rsp(input logic wr, input logic [1:0] idx, input logic [7:0] d);
      rsp_exp_t e;
      e.wr = wr; e.idx = idx; e.data = d;
      exp_rsp.push_back(e);
   endtask

   // One clock of memory model and consumer agents, driven just after posedge
   task automatic step();
      @(posedge clk);
      #2;
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      if (stale_rd) begin
         mem_read_ready = 1'b1;
         mem_read_data  = 8'hEE;
         stale_rd       = 1'b0;
      end else if (reset || !mem_en || !(mem_read_valid || mem_write_valid)) begin
         mem_cnt = 0;
      end else if (mem_cnt >= mem_lat - 1) begin
         mem_cnt = 0;
         if (mem_read_valid) begin
            mem_read_ready = 1'b1;
            mem_read_data  = mem_arr[mem_read_address];
         end else begin
            mem_write_ready = 1'b1;
         end
      end else begin
         mem_cnt++;
      end
      for (int c = 0; c < N; c++) begin
         if (rd_ready[c] && rd_valid[c]) begin
            hold_r[c]++;
            if (hold_r[c] >= 2) begin rd_valid[c] = 1'b0; hold_r[c] = 0; end
         end
         if (wr_ready[c] && wr_valid[c]) begin
            hold_w[c]++;
            if (hold_w[c] >= 2) begin wr_valid[c] = 1'b0; hold_w[c] = 0; end
         end
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_mem.size() != 0 || exp_rsp.size() != 0 || rd_valid != '0 || wr_valid != '0 ||
              rd_ready != '0 || wr_ready != '0) && k < budget) begin
         step();
         k++;
      end
      chk(name, 32'(k < budget), 32'd1);
   endtask

   // Monitor: pop and compare whenever the DUT raises a request or a ready
   logic         p_mrv, p_mwv;
   logic [7:0]   p_mra, p_mwa, p_mwd;
   logic [N-1:0] p_rr, p_wr, p_rv, p_wv;
   mem_exp_t     me;
   rsp_exp_t     re;

   initial begin
      p_mrv = 1'b0; p_mwv = 1'b0; p_mra = '0; p_mwa = '0; p_mwd = '0;
      p_rr = '0; p_wr = '0; p_rv = '0; p_wv = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (mem_read_valid && !p_mrv) begin
               if (exp_mem.size() == 0) chk("mem_rd_unexpected", 32'd1, 32'd0);
               else begin
                  me = exp_mem.pop_front();
                  chk("mem_rd_kind", 32'd0, 32'(me.wr));
                  chk("mem_rd_addr", 32'(mem_read_address), 32'(me.addr));
               end
            end
            if (mem_write_valid && !p_mwv) begin
               if (exp_mem.size() == 0) chk("mem_wr_unexpected", 32'd1, 32'd0);
               else begin
                  me = exp_mem.pop_front();
                  chk("mem_wr_kind", 32'd1, 32'(me.wr));
                  chk("mem_wr_addr", 32'(mem_write_address), 32'(me.addr));
                  chk("mem_wr_data", 32'(mem_write_data), 32'(me.data));
               end
            end
            if (mem_read_valid && p_mrv) chk("mem_rd_addr_stable", 32'(mem_read_address), 32'(p_mra));
            if (mem_write_valid && p_mwv) begin
               chk("mem_wr_addr_stable", 32'(mem_write_address), 32'(p_mwa));
               chk("mem_wr_data_stable", 32'(mem_write_data), 32'(p_mwd));
            end
            chk("mem_valid_excl", 32'(mem_read_valid && mem_write_valid), 32'd0);
            chk("ready_onehot", 32'($countones({rd_ready, wr_ready}) <= 1), 32'd1);
            for (int c = 0; c < N; c++) begin
               if (rd_ready[c] && !p_rr[c]) begin
                  if (exp_rsp.size() == 0) chk("rsp_rd_unexpected", 32'd1, 32'd0);
                  else begin
                     re = exp_rsp.pop_front();
                     chk("rsp_rd_kind", 32'd0, 32'(re.wr));
                     chk("rsp_rd_idx", 32'(c), 32'(re.idx));
                     chk("rsp_rd_data", 32'(rd_data[c]), 32'(re.data));
                  end
               end
               if (wr_ready[c] && !p_wr[c]) begin
                  if (exp_rsp.size() == 0) chk("rsp_wr_unexpected", 32'd1, 32'd0);
                  else begin
                     re = exp_rsp.pop_front();
                     chk("rsp_wr_kind", 32'd1, 32'(re.wr));
                     chk("rsp_wr_idx", 32'(c), 32'(re.idx));
                  end
               end
               if (p_rr[c]) chk("rd_ready_hold", 32'(rd_ready[c]), 32'(p_rv[c]));
               if (p_wr[c]) chk("wr_ready_hold", 32'(wr_ready[c]), 32'(p_wv[c]));
            end
            p_mrv = mem_read_valid; p_mwv = mem_write_valid;
            p_mra = mem_read_address; p_mwa = mem_write_address; p_mwd = mem_write_data;
            p_rr = rd_ready; p_wr = wr_ready; p_rv = rd_valid; p_wv = wr_valid;
         end else begin
            p_mrv = 1'b0; p_mwv = 1'b0; p_rr = '0; p_wr = '0; p_rv = '0; p_wv = '0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      reset = 1'b1;
      rd_valid = '0; wr_valid = '0;
      mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
      for (int c = 0; c < N; c++) begin
         rd_addr[c] = '0; wr_addr[c] = '0; wr_data[c] = '0; hold_r[c] = 0; hold_w[c] = 0;
      end
      for (int i = 0; i < 256; i++) mem_arr[i] = '0;
      mem_arr[8'h00] = 8'h11; mem_arr[8'h01] = 8'h22; mem_arr[8'h02] = 8'h33;
      mem_arr[8'h03] = 8'h44; mem_arr[8'h04] = 8'h55; mem_arr[8'h10] = 8'hAB;
      mem_arr[8'h30] = 8'hC3; mem_arr[8'h50] = 8'h77; mem_arr[8'h60] = 8'h66;
      mem_arr[8'h63] = 8'h99;

      repeat (3) step();
      chk("rst_mem_rd_valid", 32'(mem_read_valid), 32'd0);
      chk("rst_mem_wr_valid", 32'(mem_write_valid), 32'd0);
      chk("rst_mem_rd_addr", 32'(mem_read_address), 32'd0);
      chk("rst_mem_wr_addr", 32'(mem_write_address), 32'd0);
      chk("rst_mem_wr_data", 32'(mem_write_data), 32'd0);
      chk("rst_rd_ready", 32'(rd_ready), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_timeout", 32'(timeout_error), 32'd0);
      for (int c = 0; c < N; c++) chk("rst_rd_data", 32'(rd_data[c]), 32'd0);
      reset = 1'b0;
      step();

      // All four read together from rr_ptr 0, then c0 re-requests behind c3
      for (int c = 0; c < N; c++) rd_addr[c] = 8'(c);
      rd_valid = 4'hF;
      push_mem(1'b0, 8'h00, 8'h00); push_rsp(1'b0, 2'd0, 8'h11);
      push_mem(1'b0, 8'h01, 8'h00); push_rsp(1'b0, 2'd1, 8'h22);
      push_mem(1'b0, 8'h02, 8'h00); push_rsp(1'b0, 2'd2, 8'h33);
      push_mem(1'b0, 8'h03, 8'h00); push_rsp(1'b0, 2'd3, 8'h44);
      k = 0;
      while ((rd_valid[0] || rd_ready[0]) && k < 100) begin step(); k++; end
      chk("rr_c0_done", 32'(k < 100), 32'd1);
      rd_addr[0] = 8'h04; rd_valid[0] = 1'b1;
      push_mem(1'b0, 8'h04, 8'h00); push_rsp(1'b0, 2'd0, 8'h55);
      wait_drain("drain_rr", 200);

      // Single read, memory latency 3
      mem_lat = 3;
      rd_addr[2] = 8'h10; rd_valid[2] = 1'b1;
      push_mem(1'b0, 8'h10, 8'h00); push_rsp(1'b0, 2'd2, 8'hAB);
      wait_drain("drain_single_rd", 100);
      chk("rd_data2_after", 32'(rd_data[2]), 32'hAB);

      // Write
      mem_lat = 2;
      wr_addr[1] = 8'h20; wr_data[1] = 8'h5A; wr_valid[1] = 1'b1;
      push_mem(1'b1, 8'h20, 8'h5A); push_rsp(1'b1, 2'd1, 8'h00);
      wait_drain("drain_wr", 100);

      // Read and write from the same consumer: read first
      mem_lat = 1;
      rd_addr[3] = 8'h30; wr_addr[3] = 8'h31; wr_data[3] = 8'h77;
      rd_valid[3] = 1'b1; wr_valid[3] = 1'b1;
      push_mem(1'b0, 8'h30, 8'h00); push_rsp(1'b0, 2'd3, 8'hC3);
      push_mem(1'b1, 8'h31, 8'h77); push_rsp(1'b1, 2'd3, 8'h00);
      wait_drain("drain_rw", 100);
      chk("rd_data2_held", 32'(rd_data[2]), 32'hAB);

`ifdef DATA_ARB_TIMEOUT_EN
      // Memory never answers: watchdog completes with zero data
      mem_en = 1'b0;
      rd_addr[1] = 8'h70; rd_valid[1] = 1'b1;
      push_mem(1'b0, 8'h70, 8'h00); push_rsp(1'b0, 2'd1, 8'h00);
      wait_drain("drain_timeout", 100);
      chk("timeout_set", 32'(timeout_error), 32'd1);
      mem_en = 1'b1;
      rd_addr[0] = 8'h00; rd_valid[0] = 1'b1;
      push_mem(1'b0, 8'h00, 8'h00); push_rsp(1'b0, 2'd0, 8'h11);
      wait_drain("drain_after_timeout", 100);
      chk("timeout_sticky", 32'(timeout_error), 32'd1);
`endif

      // Reset in the middle of READ_WAIT
      mem_en = 1'b0;
      rd_addr[2] = 8'h50; rd_valid[2] = 1'b1;
      push_mem(1'b0, 8'h50, 8'h00);
      k = 0;
      while (!mem_read_valid && k < 20) begin step(); k++; end
      chk("midrst_req_seen", 32'(mem_read_valid), 32'd1);
      step();
      reset = 1'b1; rd_valid[2] = 1'b0;
      step();
      chk("midrst_mem_rd_valid", 32'(mem_read_valid), 32'd0);
      chk("midrst_mem_rd_addr", 32'(mem_read_address), 32'd0);
      chk("midrst_rd_ready", 32'(rd_ready), 32'd0);
      chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
      chk("midrst_timeout", 32'(timeout_error), 32'd0);
      for (int c = 0; c < N; c++) chk("midrst_rd_data", 32'(rd_data[c]), 32'd0);
      reset = 1'b0; stale_rd = 1'b1;
      step();
      step();
      chk("stale_mem_rd_valid", 32'(mem_read_valid), 32'd0);
      chk("stale_rd_ready", 32'(rd_ready), 32'd0);
      chk("stale_rd_data2", 32'(rd_data[2]), 32'd0);
      mem_en = 1'b1;

      // rr_ptr back at 0: c0 wins over c3
      rd_addr[0] = 8'h60; rd_addr[3] = 8'h63; rd_valid = 4'b1001;
      push_mem(1'b0, 8'h60, 8'h00); push_rsp(1'b0, 2'd0, 8'h66);
      push_mem(1'b0, 8'h63, 8'h00); push_rsp(1'b0, 2'd3, 8'h99);
      wait_drain("drain_post_rst", 100);

`ifndef DATA_ARB_TIMEOUT_EN
      chk("timeout_tied_low", 32'(timeout_error), 32'd0);
`endif
      chk("exp_mem_empty", 32'(exp_mem.size()), 32'd0);
      chk("exp_rsp_empty", 32'(exp_rsp.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
